// File: rtl/bit_scan_unit_pkg.sv
// Shared definitions for the bit-scan / normalize unit: op encodings and width helpers.
`timescale 1ns/1ps

package bit_scan_unit_pkg;

   typedef enum logic [1:0] {
      OP_CLZ = 2'b00,
      OP_CTZ = 2'b01,
      OP_POP = 2'b10,
      OP_CZ  = 2'b11
   } op_e;

   // Data width for a given ORDER.
   function automatic int unsigned data_w(input int unsigned order);
      return 32'd1 << order;
   endfunction

   // Count width: one extra bit so the all-zero case (count == W) fits.
   function automatic int unsigned count_w(input int unsigned order);
      return order + 32'd1;
   endfunction

endpackage

// File: rtl/bit_scan_unit_cix.sv
// Recursive count-in-extent tree: counts zero bits, limited to the leading run,
// the trailing run, or the whole word, depending on lead/trail.
`timescale 1ns/1ps

module bit_scan_unit_cix
   import bit_scan_unit_pkg::*;
#(
   parameter int unsigned ORDER = 3,
   localparam int unsigned W  = data_w(ORDER),
   localparam int unsigned CW = count_w(ORDER)
) (
   input  logic          lead,
   input  logic          trail,
   input  logic [W-1:0]  x,
   output logic [CW-1:0] count,
   output logic          all_zero
);

   localparam int unsigned HW  = W / 2;
   localparam int unsigned HCW = ORDER;

   logic [HCW-1:0] hi_cnt;
   logic [HCW-1:0] lo_cnt;
   logic           hi_az;
   logic           lo_az;
   logic           use_both;

   // Two single-bit leaves at the bottom; otherwise split in half and recurse.
   generate
      if (ORDER == 1) begin : g_leaf
         assign hi_cnt = ~x[1];
         assign lo_cnt = ~x[0];
         assign hi_az  = ~x[1];
         assign lo_az  = ~x[0];
      end else begin : g_node
         bit_scan_unit_cix #(.ORDER(ORDER - 1)) u_hi (
            .lead     (lead),
            .trail    (trail),
            .x        (x[W-1:HW]),
            .count    (hi_cnt),
            .all_zero (hi_az)
         );
         bit_scan_unit_cix #(.ORDER(ORDER - 1)) u_lo (
            .lead     (lead),
            .trail    (trail),
            .x        (x[HW-1:0]),
            .count    (lo_cnt),
            .all_zero (lo_az)
         );
      end
   endgenerate

   // A run continues into the far half only when the near half is entirely zero.
   always_comb begin
      use_both = (lead == trail) | (lead & hi_az) | (trail & lo_az);
      count    = '0;
      if (use_both) begin
         count = CW'(hi_cnt) + CW'(lo_cnt);
      end else if (lead) begin
         count = CW'(hi_cnt);
      end else begin
         count = CW'(lo_cnt);
      end
   end

   assign all_zero = hi_az & lo_az;

endmodule

// File: rtl/bit_scan_unit.sv
// Registered CLZ/CTZ/POPCNT/CZ unit with left-normalized operand output, latency 1.
`timescale 1ns/1ps

module bit_scan_unit
   import bit_scan_unit_pkg::*;
#(
   parameter int unsigned ORDER = 3,
   localparam int unsigned W  = data_w(ORDER),
   localparam int unsigned CW = count_w(ORDER)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [1:0]    op,
   input  logic [W-1:0]  data,
   output logic          out_valid,
   output logic [CW-1:0] count,
   output logic          zero,
   output logic [W-1:0]  norm
);

   logic          core_lead;
   logic          core_trail;
   logic [W-1:0]  core_x;
   logic [CW-1:0] core_cnt;
   logic          core_az;

   logic [W-1:0]     norm_c;
   logic [ORDER-1:0] norm_clz;
   logic [CW-1:0]    count_c;
   logic             zero_c;

   // Core controls; POP reuses the zero counter on the inverted operand.
   always_comb begin
      core_x     = data;
      core_lead  = 1'b1;
      core_trail = 1'b1;
      unique case (op_e'(op))
         OP_CLZ:  core_trail = 1'b0;
         OP_CTZ:  core_lead  = 1'b0;
         OP_POP:  core_x     = ~data;
         OP_CZ:   core_x     = data;
         default: core_x     = data;
      endcase
   end

   bit_scan_unit_cix #(.ORDER(ORDER)) u_cix (
      .lead     (core_lead),
      .trail    (core_trail),
      .x        (core_x),
      .count    (core_cnt),
      .all_zero (core_az)
   );

   // Logarithmic normalizer, widest group first; each stage yields one CLZ bit.
   always_comb begin
      int unsigned grp;
      logic        top_zero;
      norm_c   = data;
      norm_clz = '0;
      for (int unsigned k = 0; k < ORDER; k++) begin
         grp      = 32'd1 << (ORDER - 32'd1 - k);
         top_zero = (norm_c >> (W - grp)) == W'(0);
         norm_clz = (norm_clz << 1) | ORDER'(top_zero);
         if (top_zero) begin
            norm_c = norm_c << grp;
         end
      end
   end

   // The shifter saturates at W-1 on a zero word, so the core supplies CLZ == W there.
   always_comb begin
      zero_c  = ~|data;
      count_c = core_cnt;
      if ((op_e'(op) == OP_CLZ) && !core_az) begin
         count_c = CW'(norm_clz);
      end
   end

   // Output registers; data outputs hold across idle cycles.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         count     <= '0;
         zero      <= 1'b0;
         norm      <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            count <= count_c;
            zero  <= zero_c;
            norm  <= norm_c;
         end
      end
   end

endmodule

// File: tb/tb_bit_scan_unit.sv
// Directed bench for bit_scan_unit at ORDER=3 (8-bit word).
`timescale 1ns/1ps

module tb_bit_scan_unit;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic [1:0] op;
   logic [7:0] data;
   logic       out_valid;
   logic [3:0] count;
   logic       zero;
   logic [7:0] norm;

   int n_cmp = 0;
   int n_bad = 0;

   bit_scan_unit #(.ORDER(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .op        (op),
      .data      (data),
      .out_valid (out_valid),
      .count     (count),
      .zero      (zero),
      .norm      (norm)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one beat at the falling edge, then settle just after the next rising edge.
   task automatic beat(input logic v, input logic [1:0] o, input logic [7:0] d);
      @(negedge clock);
      in_valid = v;
      op       = o;
      data     = d;
      @(posedge clock);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [3:0] c,
                            input logic z, input logic [7:0] n);
      check({tag, ".valid"}, 32'(out_valid), 32'(v));
      check({tag, ".count"}, 32'(count), 32'(c));
      check({tag, ".zero"},  32'(zero), 32'(z));
      check({tag, ".norm"},  32'(norm), 32'(n));
   endtask

   function automatic logic [3:0] model_count(input logic [1:0] o, input logic [7:0] d);
      int c;
      c = 0;
      case (o)
         2'd0: for (int i = 7; i >= 0 && d[i] == 1'b0; i--) c++;
         2'd1: for (int i = 0; i < 8 && d[i] == 1'b0; i++) c++;
         2'd2: for (int i = 0; i < 8; i++) if (d[i]) c++;
         default: for (int i = 0; i < 8; i++) if (!d[i]) c++;
      endcase
      return 4'(c);
   endfunction

   function automatic logic [7:0] model_norm(input logic [7:0] d);
      logic [7:0] n;
      n = d;
      for (int i = 0; i < 8 && n != 8'h00 && n[7] == 1'b0; i++) n = n << 1;
      return n;
   endfunction

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      op       = 2'd0;
      data     = 8'h00;

      // Asynchronous reset in the middle of the low clock phase.
      #1.3;
      reset = 1'b1;
      #0.2;
      check_out("async_reset", 1'b0, 4'd0, 1'b0, 8'h00);

      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      beat(1'b0, 2'd0, 8'h5A);
      check_out("post_reset_idle", 1'b0, 4'd0, 1'b0, 8'h00);

      // Hand-computed vectors.
      beat(1'b1, 2'd0, 8'h00); check_out("z_clz", 1'b1, 4'd8, 1'b1, 8'h00);
      beat(1'b1, 2'd1, 8'h00); check_out("z_ctz", 1'b1, 4'd8, 1'b1, 8'h00);
      beat(1'b1, 2'd2, 8'h00); check_out("z_pop", 1'b1, 4'd0, 1'b1, 8'h00);
      beat(1'b1, 2'd3, 8'h00); check_out("z_cz",  1'b1, 4'd8, 1'b1, 8'h00);
      beat(1'b1, 2'd0, 8'h14); check_out("14_clz", 1'b1, 4'd3, 1'b0, 8'hA0);
      beat(1'b1, 2'd1, 8'h14); check_out("14_ctz", 1'b1, 4'd2, 1'b0, 8'hA0);
      beat(1'b1, 2'd2, 8'h14); check_out("14_pop", 1'b1, 4'd2, 1'b0, 8'hA0);
      beat(1'b1, 2'd3, 8'h14); check_out("14_cz",  1'b1, 4'd6, 1'b0, 8'hA0);
      beat(1'b1, 2'd0, 8'hFF); check_out("ff_clz", 1'b1, 4'd0, 1'b0, 8'hFF);
      beat(1'b1, 2'd1, 8'hFF); check_out("ff_ctz", 1'b1, 4'd0, 1'b0, 8'hFF);
      beat(1'b1, 2'd2, 8'hFF); check_out("ff_pop", 1'b1, 4'd8, 1'b0, 8'hFF);
      beat(1'b1, 2'd3, 8'hFF); check_out("ff_cz",  1'b1, 4'd0, 1'b0, 8'hFF);
      beat(1'b1, 2'd0, 8'h01); check_out("01_clz", 1'b1, 4'd7, 1'b0, 8'h80);
      beat(1'b1, 2'd1, 8'h01); check_out("01_ctz", 1'b1, 4'd0, 1'b0, 8'h80);
      beat(1'b1, 2'd2, 8'h01); check_out("01_pop", 1'b1, 4'd1, 1'b0, 8'h80);
      beat(1'b1, 2'd3, 8'h01); check_out("01_cz",  1'b1, 4'd7, 1'b0, 8'h80);

      // Back-to-back sweep of every operand under every op.
      for (int d = 0; d < 256; d++) begin
         for (int o = 0; o < 4; o++) begin
            beat(1'b1, 2'(o), 8'(d));
            check_out($sformatf("sweep_d%02h_op%0d", d, o), 1'b1,
                      model_count(2'(o), 8'(d)), (d == 0), model_norm(8'(d)));
            if (d != 0) check($sformatf("sweep_msb_d%02h_op%0d", d, o), 32'(norm[7]), 32'd1);
         end
      end

      // Idle cycles drop out_valid and hold data outputs.
      beat(1'b1, 2'd0, 8'h14); check_out("pre_idle", 1'b1, 4'd3, 1'b0, 8'hA0);
      beat(1'b0, 2'd2, 8'hFF); check_out("idle1", 1'b0, 4'd3, 1'b0, 8'hA0);
      beat(1'b0, 2'd3, 8'h00); check_out("idle2", 1'b0, 4'd3, 1'b0, 8'hA0);
      beat(1'b1, 2'd2, 8'hFF); check_out("resume", 1'b1, 4'd8, 1'b0, 8'hFF);
      beat(1'b0, 2'd1, 8'h01); check_out("idle3", 1'b0, 4'd8, 1'b0, 8'hFF);

      // Reset with a beat in flight: the beat is discarded.
      @(negedge clock);
      in_valid = 1'b1;
      op       = 2'd0;
      data     = 8'h01;
      #2;
      reset = 1'b1;
      #0.5;
      check_out("mid_reset_now", 1'b0, 4'd0, 1'b0, 8'h00);
      @(posedge clock);
      #1;
      check_out("mid_reset_edge", 1'b0, 4'd0, 1'b0, 8'h00);
      @(negedge clock);
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clock);
      #1;
      check_out("after_reset_idle", 1'b0, 4'd0, 1'b0, 8'h00);
      beat(1'b1, 2'd1, 8'h14); check_out("after_reset_beat", 1'b1, 4'd2, 1'b0, 8'hA0);
      beat(1'b0, 2'd0, 8'h00); check_out("after_reset_idle2", 1'b0, 4'd2, 1'b0, 8'hA0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
